// File: rtl/mxint8_block_loader_pkg.sv
// Shared definitions for the MXINT8 block loader: default data widths and
// block size, plus the per-bank state encoding.
package mxint8_block_loader_pkg;

    localparam int DEF_SCALE_WIDTH   = 8;   // E8M0 shared exponent
    localparam int DEF_ELEMENT_WIDTH = 8;   // two's-complement MXINT8 element
    localparam int DEF_BLOCK_SIZE    = 32;  // elements per MX block

    // Lifecycle of one buffer bank.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Width of a fill index covering 0..bs-1; never narrower than one bit.
    function automatic int idx_width(input int bs);
        return (bs > 1) ? $clog2(bs) : 1;
    endfunction

endpackage

// File: rtl/mxint8_block_loader_bank.sv
// One buffer bank: shared scale register, BLOCK_SIZE element registers and
// the EMPTY/FILLING/FULL state. Elements live in flops because the whole
// block is presented in parallel to the summer.
module mxint8_block_loader_bank
    import mxint8_block_loader_pkg::*;
#(
    parameter int SCALE_WIDTH          = DEF_SCALE_WIDTH,
    parameter int MXINT8_ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int BLOCK_SIZE           = DEF_BLOCK_SIZE,
    localparam int IDX_W               = idx_width(BLOCK_SIZE)
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_wr_en,
    input  logic [IDX_W-1:0]                                 i_wr_idx,
    input  logic [SCALE_WIDTH-1:0]                           i_wr_scale,
    input  logic [MXINT8_ELEMENT_WIDTH-1:0]                  i_wr_elem,
    input  logic                                             i_drain,
    input  logic                                             i_abort,
    output bank_state_e                                      o_state,
    output logic [SCALE_WIDTH-1:0]                           o_scale,
    output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]  o_elements
);

    bank_state_e                state_q, state_d;
    logic [SCALE_WIDTH-1:0]     scale_q;
    logic                       wr_last;

    assign wr_last = (i_wr_idx == IDX_W'(BLOCK_SIZE - 1));

    // Bank state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= BANK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: drain frees a full bank, abort discards a partial one,
    // a write starts or completes the fill.
    always_comb begin
        state_d = state_q;
        if (i_drain) begin
            state_d = BANK_EMPTY;
        end else if (i_abort) begin
            if (state_q == BANK_FILLING) begin
                state_d = BANK_EMPTY;
            end
        end else if (i_wr_en) begin
            state_d = wr_last ? BANK_FULL : BANK_FILLING;
        end
    end

    // Scale is captured only on the element-0 beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scale_q <= '0;
        end else if (i_wr_en && (i_wr_idx == '0)) begin
            scale_q <= i_wr_scale;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
            logic [MXINT8_ELEMENT_WIDTH-1:0] elem_q;

            // Element gi is written by the beat carrying index gi, bit-exact.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    elem_q <= '0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
                    elem_q <= i_wr_elem;
                end
            end

            assign o_elements[gi] = elem_q;
        end
    endgenerate

    assign o_state = state_q;
    assign o_scale = scale_q;

endmodule

// File: rtl/mxint8_block_loader.sv
// MXINT8 block loader: collects a shared scale plus BLOCK_SIZE elements from
// a valid/ready stream into one of two ping-pong banks and presents each
// completed block in parallel. One bank fills while the other is held.
module mxint8_block_loader
    import mxint8_block_loader_pkg::*;
#(
    parameter int SCALE_WIDTH          = DEF_SCALE_WIDTH,
    parameter int MXINT8_ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int BLOCK_SIZE           = DEF_BLOCK_SIZE,
    localparam int IDX_W               = idx_width(BLOCK_SIZE),
    localparam int FILL_W              = $clog2(BLOCK_SIZE + 1)
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_in_valid,
    output logic                                             o_in_ready,
    input  logic [SCALE_WIDTH-1:0]                           i_in_scale,
    input  logic [MXINT8_ELEMENT_WIDTH-1:0]                  i_in_element,
    input  logic                                             i_abort,
    output logic                                             o_out_valid,
    input  logic                                             i_out_ready,
    output logic [SCALE_WIDTH-1:0]                           o_scale,
    output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]  o_mxint8_elements,
    output logic [FILL_W-1:0]                                o_fill_count
);

    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]    index_q, index_d;

    bank_state_e                                      bank_state [2];
    logic [SCALE_WIDTH-1:0]                           bank_scale [2];
    logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]  bank_elems [2];

    logic in_accept, wr_en, out_accept, last_beat;

    // Both handshake flags come from registered bank state only.
    assign o_in_ready  = (bank_state[wr_bank_q] != BANK_FULL);
    assign o_out_valid = (bank_state[rd_bank_q] == BANK_FULL);

    assign in_accept  = i_in_valid & o_in_ready;
    assign wr_en      = in_accept & ~i_abort;      // abort drops a same-cycle beat
    assign out_accept = o_out_valid & i_out_ready;
    assign last_beat  = (index_q == IDX_W'(BLOCK_SIZE - 1));

    // Fill index and bank pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            index_q   <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            index_q   <= index_d;
        end
    end

    // Advance the fill index per beat, swap banks on completion and drain.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        index_d   = index_q;
        if (i_abort) begin
            index_d = '0;
        end else if (wr_en) begin
            if (last_beat) begin
                index_d   = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                index_d = index_q + 1'b1;
            end
        end
        if (out_accept) begin
            rd_bank_d = ~rd_bank_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            mxint8_block_loader_bank #(
                .SCALE_WIDTH          (SCALE_WIDTH),
                .MXINT8_ELEMENT_WIDTH (MXINT8_ELEMENT_WIDTH),
                .BLOCK_SIZE           (BLOCK_SIZE)
            ) u_bank (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_wr_en    (wr_en && (wr_bank_q == 1'(gi))),
                .i_wr_idx   (index_q),
                .i_wr_scale (i_in_scale),
                .i_wr_elem  (i_in_element),
                .i_drain    (out_accept && (rd_bank_q == 1'(gi))),
                .i_abort    (i_abort && (wr_bank_q == 1'(gi))),
                .o_state    (bank_state[gi]),
                .o_scale    (bank_scale[gi]),
                .o_elements (bank_elems[gi])
            );
        end
    endgenerate

    assign o_scale           = bank_scale[rd_bank_q];
    assign o_mxint8_elements = bank_elems[rd_bank_q];
    assign o_fill_count      = FILL_W'(index_q);

endmodule
